// File: rtl/alu_rr_scheduler_if.sv
// Bundles the two requester ports, the ALU operand/result path and the tagged response
// channel of the round-robin ALU scheduler.
interface alu_rr_scheduler_if #(parameter int WIDTH = 8);
  logic               req0;
  logic [1:0]         ctrl0;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   b0;
  logic               gnt0;
  logic               req1;
  logic [1:0]         ctrl1;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b1;
  logic               gnt1;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [1:0]         alu_ctrl;
  logic [2*WIDTH-1:0] alu_out;
  logic               rsp_valid;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_data;
  logic               rsp_ready;

  modport slave (
    input  req0, ctrl0, a0, b0, req1, ctrl1, a1, b1, alu_out, rsp_ready,
    output gnt0, gnt1, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req0, ctrl0, a0, b0, req1, ctrl1, a1, b1, alu_out, rsp_ready,
    input  gnt0, gnt1, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin sharing of one registered ALU between two requesters, one operation in flight,
// result returned on a valid/ready channel tagged with the owning requester.
module alu_rr_scheduler #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  alu_rr_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, HOLD} state_t;

  state_t           state;
  state_t           next_state;
  logic             last;
  logic             win;
  logic             issue;
  logic             capture;
  logic             rsp_done;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [1:0]       sel_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.req0 || bus.req1) next_state = ISSUE;
      ISSUE:   next_state = CAPT;
      CAPT:    next_state = HOLD;
      HOLD:    if (bus.rsp_valid && bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With both requesting, the one not served last wins; a lone requester always wins.
  always_comb begin
    win      = 1'b0;
    issue    = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    win      = (bus.req0 && bus.req1) ? ~last : bus.req1;
    issue    = (state == IDLE) && (bus.req0 || bus.req1);
    capture  = (state == CAPT);
    rsp_done = (state == HOLD) && bus.rsp_valid && bus.rsp_ready;
    sel_a    = win ? bus.a1    : bus.a0;
    sel_b    = win ? bus.b1    : bus.b0;
    sel_ctrl = win ? bus.ctrl1 : bus.ctrl0;
  end

  // ALU operands only load on issue so the ALU inputs stay quiet between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.gnt0      <= 1'b0;
      bus.gnt1      <= 1'b0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_ctrl  <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
      last          <= 1'b1;
    end else begin
      bus.gnt0 <= issue && !win;
      bus.gnt1 <= issue && win;
      if (issue) begin
        bus.alu_a    <= sel_a;
        bus.alu_b    <= sel_b;
        bus.alu_ctrl <= sel_ctrl;
        bus.rsp_id   <= win;
        last         <= win;
      end
      if (capture) begin
        bus.rsp_data  <= bus.alu_out;
        bus.rsp_valid <= 1'b1;
      end else if (rsp_done) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: a registered ALU model, queued expected grants and
// responses, and a negedge monitor that checks order, latency, spacing and hold stability.
module tb_alu_rr_scheduler;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [16:0] exp_rsp[$];
  logic        exp_gnt[$];

  alu_rr_scheduler_if #(.WIDTH(WIDTH)) bus();

  alu_rr_scheduler #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the shared ALU: one register stage, operands sign-extended to 16 bits.
  logic signed [15:0] sa;
  logic signed [15:0] sb;
  always_comb begin
    sa = {{8{bus.alu_a[7]}}, bus.alu_a};
    sb = {{8{bus.alu_b[7]}}, bus.alu_b};
  end

  always @(posedge clk or posedge rst) begin
    if (rst) bus.alu_out <= '0;
    else begin
      case (bus.alu_ctrl)
        2'd0:    bus.alu_out <= sa * sb;
        2'd1:    bus.alu_out <= sa - sb;
        2'd2:    bus.alu_out <= {bus.alu_a & bus.alu_b, bus.alu_a | bus.alu_b};
        default: bus.alu_out <= sa >>> 3;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit id, input logic [1:0] ctrl, input logic [7:0] a,
                               input logic [7:0] b, input logic [15:0] exp_data,
                               input bit expect_rsp);
    if (!id) begin
      bus.req0 = 1'b1; bus.ctrl0 = ctrl; bus.a0 = a; bus.b0 = b;
    end else begin
      bus.req1 = 1'b1; bus.ctrl1 = ctrl; bus.a1 = a; bus.b1 = b;
    end
    exp_gnt.push_back(id);
    if (expect_rsp) exp_rsp.push_back({id, exp_data});
  endtask

  task automatic waitGrants(input int n, input bit drop);
    int seen = 0;
    for (int i = 0; i < 100 && seen < n; i++) begin
      @(posedge clk); #1;
      if (bus.gnt0 || bus.gnt1) begin
        seen++;
        if (drop) begin
          if (bus.gnt0) bus.req0 = 1'b0;
          if (bus.gnt1) bus.req1 = 1'b0;
        end
      end
    end
    checkOutput("grant_count", 64'(seen), 64'(n));
  endtask

  task automatic waitRspValid();
    for (int i = 0; i < 50 && !bus.rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("rsp_valid_seen", 64'(bus.rsp_valid), 64'd1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && (exp_rsp.size() + exp_gnt.size()) != 0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("drain_pending", 64'(exp_rsp.size() + exp_gnt.size()), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Monitor: grant order/spacing, grant-to-valid latency, HOLD stability and response order.
  logic        have_gnt = 1'b0;
  int          last_gnt_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [16:0] prev_rsp = '0;
  logic [16:0] popped;

  always @(negedge clk) begin
    if (rst) begin
      have_gnt   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (bus.gnt0 || bus.gnt1) begin
        if (exp_gnt.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL grant_unexpected: got gnt0=%0d gnt1=%0d expected none", bus.gnt0, bus.gnt1);
        end else begin
          checkOutput("grant_id", {bus.gnt1, bus.gnt0}, exp_gnt[0] ? 64'd2 : 64'd1);
          void'(exp_gnt.pop_front());
        end
        if (have_gnt) checkOutput("grant_spacing_ok", 64'(cyc - last_gnt_cyc >= 4), 64'd1);
        checkOutput("grant_during_rsp", 64'(bus.rsp_valid), 64'd0);
        have_gnt     = 1'b1;
        last_gnt_cyc = cyc;
      end
      if (bus.rsp_valid && !prev_valid) begin
        if (!have_gnt) begin
          checks++; errors++;
          $display("[TB] FAIL rsp_without_grant: got rsp_valid=1 expected 0");
        end else checkOutput("rsp_latency", 64'(cyc - last_gnt_cyc), 64'd2);
      end
      if (bus.rsp_valid && prev_valid)
        checkOutput("hold_stable", {bus.rsp_id, bus.rsp_data}, prev_rsp);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL rsp_unexpected: got id=%0d data=%0h expected none", bus.rsp_id, bus.rsp_data);
        end else begin
          popped = exp_rsp.pop_front();
          checkOutput("rsp_id_data", {bus.rsp_id, bus.rsp_data}, popped);
        end
      end
      prev_valid = bus.rsp_valid;
      prev_rsp   = {bus.rsp_id, bus.rsp_data};
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req0 = 1'b0; bus.ctrl0 = '0; bus.a0 = '0; bus.b0 = '0;
    bus.req1 = 1'b0; bus.ctrl1 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    #12;
    checkOutput("reset_outputs",
                {bus.gnt0, bus.gnt1, bus.alu_a, bus.alu_b, bus.alu_ctrl,
                 bus.rsp_valid, bus.rsp_id, bus.rsp_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single mul from requester 0");
    applyStimulus(1'b0, 2'd0, 8'hFD, 8'd5, 16'hFFF1, 1'b1);
    waitGrants(1, 1'b1);
    waitDrain();

    $display("[TB] simultaneous requests after reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b0, 2'd2, 8'hF0, 8'h3C, 16'h30FC, 1'b1);
    applyStimulus(1'b1, 2'd1, 8'h80, 8'h01, 16'hFF7F, 1'b1);
    waitGrants(2, 1'b1);
    waitDrain();

    $display("[TB] both held for four operations");
    applyStimulus(1'b0, 2'd0, 8'd7, 8'hFE, 16'hFFF2, 1'b1);
    applyStimulus(1'b1, 2'd1, 8'd100, 8'h9C, 16'h00C8, 1'b1);
    applyStimulus(1'b0, 2'd0, 8'd7, 8'hFE, 16'hFFF2, 1'b1);
    applyStimulus(1'b1, 2'd1, 8'd100, 8'h9C, 16'h00C8, 1'b1);
    waitGrants(4, 1'b0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    waitDrain();

    $display("[TB] backpressure in HOLD with a waiting requester");
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b1, 2'd3, 8'h90, 8'h00, 16'hFFF2, 1'b1);
    waitGrants(1, 1'b1);
    applyStimulus(1'b0, 2'd1, 8'd10, 8'd3, 16'h0007, 1'b1);
    waitRspValid();
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("hold_valid", 64'(bus.rsp_valid), 64'd1);
    checkOutput("hold_data", {bus.rsp_id, bus.rsp_data}, {1'b1, 16'hFFF2});
    checkOutput("hold_no_gnt", {bus.gnt0, bus.gnt1}, 64'd0);
    bus.rsp_ready = 1'b1;
    waitGrants(1, 1'b1);
    waitDrain();

    $display("[TB] one-cycle request pulse");
    applyStimulus(1'b0, 2'd1, 8'd5, 8'd9, 16'hFFFC, 1'b1);
    waitGrants(1, 1'b1);
    waitDrain();
    repeat (6) begin @(posedge clk); #1; end
    checkOutput("alu_inputs_hold", {bus.alu_ctrl, bus.alu_a, bus.alu_b}, {2'd1, 8'd5, 8'd9});

    $display("[TB] reset during capture");
    applyStimulus(1'b0, 2'd0, 8'd2, 8'd2, 16'h0004, 1'b0);
    waitGrants(1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_outputs",
                {bus.gnt0, bus.gnt1, bus.alu_a, bus.alu_b, bus.alu_ctrl,
                 bus.rsp_valid, bus.rsp_id, bus.rsp_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    applyStimulus(1'b1, 2'd2, 8'h0F, 8'hF3, 16'h03FF, 1'b1);
    waitGrants(1, 1'b1);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
